// File: rtl/weight_sram_reader.sv
// Streams a burst of weight words from a one-cycle-latency SRAM into a small
// output FIFO with valid/ready flow control, range checking and abort.
module weight_sram_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 81920
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic [16:0] base_addr,
  input  logic [16:0] length,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic [31:0] mem_addr,
  output logic        mem_W_req,
  output logic [31:0] mem_W_data,
  input  logic [31:0] mem_R_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [16:0]   r_base;
  logic [16:0]   r_len;
  logic [16:0]   r_issued;
  logic [16:0]   r_captured;
  logic [16:0]   r_mem_addr;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_fifo_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic          r_fifo_last [FIFO_DEPTH];
  logic          r_mem_cs;
  logic          r_cap;
  logic          r_done;
  logic          r_err;

  logic [17:0]   w_sum;
  logic          w_pop;
  logic          w_room;
  logic          w_accept;
  logic          w_reject;
  logic          w_zero;
  logic          w_issue;
  logic          w_finish;

  assign w_sum  = {1'b0, base_addr} + {1'b0, length};
  assign w_pop  = out_valid && out_ready;
  // Outstanding counts every issued word not yet popped, so the FIFO can never overflow.
  assign w_room = (r_outstanding - CW'(w_pop)) < CW'(FIFO_DEPTH);

  // Next-state and per-cycle control decisions
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_zero      = 1'b0;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_sum > 18'(MEM_WORDS)) begin
              w_reject = 1'b1;
            end else if (length == 17'd0) begin
              w_zero = 1'b1;
            end else begin
              w_accept    = 1'b1;
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_issue = (r_issued != r_len) && w_room;
          if (w_pop && out_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_issued == r_len) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && out_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst counters, read issue and capture pipeline; abort drops in-flight data
  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      r_base        <= 17'd0;
      r_len         <= 17'd0;
      r_issued      <= 17'd0;
      r_captured    <= 17'd0;
      r_mem_addr    <= 17'd0;
      r_outstanding <= CW'(0);
      r_mem_cs      <= 1'b0;
      r_cap         <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= w_zero || w_finish;
      r_err  <= w_reject;
      r_cap  <= r_mem_cs;
      if (w_accept) begin
        r_base        <= base_addr;
        r_len         <= length;
        r_issued      <= 17'd1;
        r_captured    <= 17'd0;
        r_mem_addr    <= base_addr;
        r_mem_cs      <= 1'b1;
        r_outstanding <= CW'(1);
      end else begin
        r_mem_cs      <= w_issue;
        r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_pop);
        if (w_issue) begin
          r_mem_addr <= r_base + r_issued;
          r_issued   <= r_issued + 17'd1;
        end
        if (r_cap) begin
          r_captured <= r_captured + 17'd1;
        end
      end
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      r_wr_ptr   <= AW'(0);
      r_rd_ptr   <= AW'(0);
      r_fifo_cnt <= CW'(0);
    end else begin
      if (r_cap) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + CW'(r_cap) - CW'(w_pop);
    end
  end

  // Output FIFO storage; the last flag is tagged when the word lands
  always_ff @(posedge clk) begin
    if (r_cap) begin
      r_fifo_data[r_wr_ptr] <= mem_R_data;
      r_fifo_last[r_wr_ptr] <= (r_captured == (r_len - 17'd1));
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign out_valid  = (r_fifo_cnt != CW'(0));
  assign out_data   = out_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign out_last   = out_valid && r_fifo_last[r_rd_ptr];
  assign mem_cs     = r_mem_cs;
  assign mem_oe     = busy;
  assign mem_addr   = {15'd0, r_mem_addr};
  assign mem_W_req  = 1'b1;
  assign mem_W_data = 32'd0;

endmodule

// File: tb/tb_weight_sram_reader.sv
// Scoreboard bench for weight_sram_reader: a reference model expands each
// start into expected reads and words; a monitor checks them as they appear.
module tb_weight_sram_reader;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_WORDS  = 81920;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [16:0] base_addr = 17'd0;
  logic [16:0] length = 17'd0;
  logic        busy, done, err, out_valid, out_last, mem_cs, mem_oe, mem_W_req;
  logic [31:0] out_data, mem_addr, mem_W_data, mem_R_data;

  int n_tests = 0, n_fail = 0;
  int cs_cnt = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0, outst = 0, rmode = 0;
  logic [16:0] last_cs_addr = 17'd0;
  logic [32:0] exp_q[$];
  logic [16:0] addr_q[$];

  weight_sram_reader #(.FIFO_DEPTH(FIFO_DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_W_req(mem_W_req),
    .mem_W_data(mem_W_data), .mem_R_data(mem_R_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [16:0] a);
    logic [31:0] x;
    x = {15'd0, a};
    return (x * 32'h9E37_79B1) ^ 32'hA5C3_0000 ^ x;
  endfunction

  // SRAM model: data appears the cycle after chip select
  always @(posedge clk) begin
    if (mem_cs) mem_R_data <= mem_fn(mem_addr[16:0]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: 0 = accepted, 1 = immediate done, 2 = rejected
  function automatic int push_ref(input logic [16:0] b, input logic [16:0] l);
    logic [17:0] s;
    logic [16:0] a;
    s = {1'b0, b} + {1'b0, l};
    if (s > 18'(MEM_WORDS)) return 2;
    if (l == 17'd0) return 1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 17'(i);
      exp_q.push_back({(i == int'(l) - 1), mem_fn(a)});
      addr_q.push_back(a);
    end
    return 0;
  endfunction

  // Consumer ready pattern
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = 1'b0;
        3: out_ready = ~out_ready;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: reads, words, hold stability, occupancy, pulse counting
  initial begin
    logic        hold;
    logic [32:0] hold_v;
    logic [32:0] e;
    logic [16:0] a;
    hold = 1'b0;
    hold_v = 33'd0;
    forever begin
      @(negedge clk);
      if (hold) check("hold_stable", {out_valid, out_last, out_data}, {1'b1, hold_v});
      if (mem_cs) begin
        cs_cnt++;
        outst++;
        last_cs_addr = mem_addr[16:0];
        check("read_expected", (addr_q.size() != 0), 1'b1);
        if (addr_q.size() != 0) begin
          a = addr_q.pop_front();
          check("mem_addr", mem_addr, {15'd0, a});
        end
        check("occupancy_le_depth", (outst <= FIFO_DEPTH), 1'b1);
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        outst--;
        check("word_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_word", {out_last, out_data}, e);
        end
      end
      hold = out_valid && !out_ready && !abort && rstn;
      hold_v = {out_last, out_data};
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (abort || !rstn) begin
        exp_q.delete();
        addr_q.delete();
        outst = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic [16:0] b, input logic [16:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_start(input logic [16:0] b, input logic [16:0] l, output int kind);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    kind = push_ref(b, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_resp(input int d0, input int e0, output int n);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 3000) begin
      tick();
      n++;
    end
    check("response_seen", (done_cnt != d0) || (err_cnt != e0), 1'b1);
  endtask

  task automatic end_checks(input int kind, input int l, input int n, input int d0, input int e0,
                            input int c0, input int p0);
    check("idle_at_response", busy, 1'b0);
    if (kind != 0) begin
      check("immediate_response", n, 1);
      repeat (3) tick();
    end
    check("done_pulses", done_cnt - d0, (kind != 2));
    check("err_pulses", err_cnt - e0, (kind == 2));
    check("reads_issued", cs_cnt - c0, (kind == 0) ? l : 0);
    check("words_delivered", pop_cnt - p0, (kind == 0) ? l : 0);
    check("scoreboard_empty", exp_q.size() + addr_q.size(), 0);
  endtask

  task automatic run_burst(input logic [16:0] b, input logic [16:0] l, input int m);
    int d0, e0, c0, p0, kind, n;
    d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt; p0 = pop_cnt;
    rmode = m;
    do_start(b, l, kind);
    wait_resp(d0, e0, n);
    end_checks(kind, int'(l), n, d0, e0, c0, p0);
  endtask

  task automatic cut_burst(input bit use_reset);
    int d0, c0, p0, kind, n;
    rmode = 1;
    d0 = done_cnt; p0 = pop_cnt;
    do_start(17'h00200, 17'd12, kind);
    n = 0;
    while (pop_cnt - p0 < 5 && n < 500) begin tick(); n++; end
    check("reached_word5", (pop_cnt - p0 >= 5), 1'b1);
    @(posedge clk); #1;
    if (use_reset) rstn = 1'b0; else abort = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1; abort = 1'b0;
    c0 = cs_cnt;
    @(negedge clk); #1;
    check("cut_idle", {busy, out_valid, mem_cs, done, err}, 5'd0);
    if (use_reset) check("reset_addr_data", {mem_addr, out_data}, 64'd0);
    repeat (6) tick();
    check("cut_no_done", done_cnt - d0, 0);
    check("cut_no_reads", cs_cnt - c0, 0);
    run_burst(17'd0, 17'd2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int kind, d0, e0, c0, p0, n;
    logic [12:0] cs_v, v_v, l_v, d_v, cs_e, v_e, l_e, d_e;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctrl", {busy, done, err, out_valid, out_last, mem_cs, mem_oe, mem_W_req}, 8'b0000_0001);
    check("reset_buses", {mem_addr, out_data}, 64'd0);
    check("reset_wdata", mem_W_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) tick();

    // Cycle-exact latency and throughput of an 8-word burst
    rmode = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 17'h00010; length = 17'd8;
    kind = push_ref(17'h00010, 17'd8);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk); #1;
      cs_v[k] = mem_cs; v_v[k] = out_valid; l_v[k] = out_last; d_v[k] = done;
      if (k == 0) begin
        check("oe_idle_cycle0", mem_oe, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    cs_e = 13'd0; v_e = 13'd0; l_e = 13'd0; d_e = 13'd0;
    for (int k = 1; k <= 8; k++) cs_e[k] = 1'b1;
    for (int k = 3; k <= 10; k++) v_e[k] = 1'b1;
    l_e[10] = 1'b1;
    d_e[11] = 1'b1;
    check("lat_mem_cs", cs_v, cs_e);
    check("lat_out_valid", v_v, v_e);
    check("lat_out_last", l_v, l_e);
    check("lat_done", d_v, d_e);
    check("lat_done_count", done_cnt - d0, 1);

    // Bank-crossing burst with toggling ready
    run_burst(17'h03FFE, 17'd4, 3);

    // Range check at the top of memory
    run_burst(17'h13FFC, 17'd5, 0);
    run_burst(17'h13FFC, 17'd4, 0);
    check("top_last_addr", last_cs_addr, 17'h13FFF);

    // Zero-length burst
    run_burst(17'h00040, 17'd0, 0);

    // Consumer stall: only FIFO_DEPTH reads outstanding
    d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt; p0 = pop_cnt;
    rmode = 2;
    repeat (2) tick();
    do_start(17'h01000, 17'd16, kind);
    repeat (20) tick();
    check("stall_reads", cs_cnt - c0, FIFO_DEPTH);
    check("stall_pops", pop_cnt - p0, 0);
    check("stall_valid", out_valid, 1'b1);
    rmode = 0;
    wait_resp(d0, e0, n);
    end_checks(kind, 16, n, d0, e0, c0, p0);

    // Start while busy is ignored, even with out-of-range parameters
    d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt; p0 = pop_cnt;
    rmode = 1;
    do_start(17'h00100, 17'd10, kind);
    repeat (2) tick();
    pulse_start(17'h1FFFF, 17'd5);
    wait_resp(d0, e0, n);
    end_checks(kind, 10, n, d0, e0, c0, p0);

    // Abort has priority over start in IDLE
    d0 = done_cnt; e0 = err_cnt; c0 = cs_cnt;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; base_addr = 17'h00300; length = 17'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (4) tick();
    check("abort_start_reads", cs_cnt - c0, 0);
    check("abort_start_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    // Abort and reset in the middle of a burst
    cut_burst(1'b0);
    cut_burst(1'b1);

    // Randomised bursts, biased towards the top of memory
    for (int t = 0; t < 24; t++) begin
      logic [16:0] b, l;
      int m;
      if ($urandom_range(0, 2) == 0) b = 17'(MEM_WORDS - int'($urandom_range(0, 30)));
      else b = 17'($urandom_range(0, 131071));
      l = 17'($urandom_range(0, 30));
      m = int'($urandom_range(0, 3));
      if (m == 2) m = 1;
      run_burst(b, l, m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
